cart_mem_arbiter: RTL and testbench

//  Single-port arbiter between a slot mapper's CPU path and the cartridge SRAM backup/restore engine.

---
 rtl/cart_mem_pkg.sv | 14 +
 rtl/cart_mem_arbiter_if.sv | 23 ++
 rtl/cart_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
package cart_mem_pkg;

  localparam int unsigned ADDR_W   = 25;
  localparam logic [7:0]  RAM_FILL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    BK_ACC,
    DONE
  } arb_state_t;

endpackage

// File: rtl/cart_mem_arbiter_if.sv
// Shared external RAM request/ready port; the arbiter is the master side.
interface cart_mem_arbiter_if #(
  parameter int unsigned ADDR_W = cart_mem_pkg::ADDR_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic              ram_rd;
  logic              ram_we;
  logic              ram_ready;

  modport master (
    output ram_addr, ram_din, ram_rd, ram_we,
    input  ram_dout, ram_ready
  );

  modport slave (
    input  ram_addr, ram_din, ram_rd, ram_we,
    output ram_dout, ram_ready
  );

endinterface

// File: rtl/cart_mem_arbiter.sv
// Single-port arbiter between the mapper CPU path and the SRAM backup engine:
// one-deep CPU pending slot, starvation-bounded backup grants, strobe timeout.
module cart_mem_arbiter #(
  parameter int unsigned ADDR_W     = cart_mem_pkg::ADDR_W,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_unmaped,
  input  logic              cpu_wr_en,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_wait,
  input  logic              bk_req,
  input  logic              bk_wr,
  input  logic [ADDR_W-1:0] bk_addr,
  input  logic [7:0]        bk_din,
  output logic [7:0]        bk_dout,
  output logic              bk_ack,
  cart_mem_arbiter_if.master ram,
  output logic              err_timeout,
  output logic              err_overrun
);
  import cart_mem_pkg::*;

  localparam int unsigned    SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [7:0]     TO_LAST    = 8'(TIMEOUT - 1);

  arb_state_t        state, state_nxt;
  logic              pend, p_wr, p_null;
  logic [ADDR_W-1:0] p_addr;
  logic [7:0]        p_din;
  logic              own_cpu;
  logic [SW-1:0]     starve;
  logic [7:0]        tcnt;

  logic cpu_act, req_ok, force_bk, real_pend, in_acc;
  logic grant_cpu, grant_bk, finish, timed_out;
  logic [7:0] rd_data;

  assign cpu_act   = (state == CPU_ACC) || ((state == DONE) && own_cpu);
  assign req_ok    = cpu_req && !pend && !cpu_act;
  assign force_bk  = bk_req && (starve == STARVE_LIM);
  assign real_pend = pend && !p_null;
  assign in_acc    = (state == CPU_ACC) || (state == BK_ACC);
  assign rd_data   = timed_out ? RAM_FILL : ram.ram_dout;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A fresh CPU request arriving alongside bk_req holds off the backup grant
  // for the one cycle it takes to reach the pending slot, unless starved.
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_bk  = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (real_pend && !force_bk) begin
          grant_cpu = 1'b1;
          state_nxt = CPU_ACC;
        end else if (bk_req && (force_bk || !req_ok)) begin
          grant_bk  = 1'b1;
          state_nxt = BK_ACC;
        end
      end
      CPU_ACC, BK_ACC: begin
        if (ram.ram_ready) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (tcnt == TO_LAST) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend         <= 1'b0;
      p_wr         <= 1'b0;
      p_null       <= 1'b0;
      p_addr       <= '0;
      p_din        <= '0;
      own_cpu      <= 1'b0;
      starve       <= '0;
      tcnt         <= '0;
      cpu_dout     <= RAM_FILL;
      bk_dout      <= RAM_FILL;
      cpu_wait     <= 1'b0;
      bk_ack       <= 1'b0;
      ram.ram_addr <= '0;
      ram.ram_din  <= '0;
      ram.ram_rd   <= 1'b0;
      ram.ram_we   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      bk_ack <= 1'b0;

      if (cpu_req && !req_ok) err_overrun <= 1'b1;
      if (req_ok) begin
        pend     <= 1'b1;
        p_wr     <= cpu_wr;
        p_null   <= cpu_unmaped || (cpu_wr && !cpu_wr_en);
        p_addr   <= cpu_addr;
        p_din    <= cpu_din;
        cpu_wait <= 1'b1;
      end

      // Unmapped or protected accesses never touch RAM and retire at once.
      if (pend && p_null) begin
        pend     <= 1'b0;
        cpu_wait <= 1'b0;
        if (!p_wr) cpu_dout <= RAM_FILL;
      end

      if (grant_cpu) begin
        pend         <= 1'b0;
        own_cpu      <= 1'b1;
        tcnt         <= '0;
        ram.ram_addr <= p_addr;
        ram.ram_din  <= p_din;
        ram.ram_rd   <= !p_wr;
        ram.ram_we   <= p_wr;
      end
      if (grant_bk) begin
        own_cpu      <= 1'b0;
        tcnt         <= '0;
        ram.ram_addr <= bk_addr;
        ram.ram_din  <= bk_din;
        ram.ram_rd   <= !bk_wr;
        ram.ram_we   <= bk_wr;
      end

      if (in_acc && !finish) tcnt <= tcnt + 8'd1;

      if (finish) begin
        ram.ram_rd <= 1'b0;
        ram.ram_we <= 1'b0;
        if (ram.ram_rd) begin
          if (own_cpu) cpu_dout <= rd_data;
          else         bk_dout  <= rd_data;
        end
        if (timed_out) err_timeout <= 1'b1;
        if (!own_cpu)  bk_ack      <= 1'b1;
      end

      if ((state == DONE) && own_cpu) cpu_wait <= 1'b0;

      if (!bk_req || grant_bk)                   starve <= '0;
      else if (grant_cpu && starve != STARVE_LIM) starve <= starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter with a behavioural RAM responder.
module tb_cart_mem_arbiter;
  import cart_mem_pkg::*;

  localparam int unsigned AW = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_wr = 1'b0, cpu_unmaped = 1'b0, cpu_wr_en = 1'b0;
  logic [AW-1:0] cpu_addr = '0, bk_addr = '0;
  logic [7:0]    cpu_din = '0, bk_din = '0, cpu_dout, bk_dout;
  logic          cpu_wait, bk_req = 1'b0, bk_wr = 1'b0, bk_ack;
  logic          err_timeout, err_overrun;

  cart_mem_arbiter_if #(.ADDR_W(AW)) ram_bus ();

  cart_mem_arbiter #(.ADDR_W(AW), .TIMEOUT(8), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_unmaped(cpu_unmaped),
    .cpu_wr_en(cpu_wr_en), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
    .bk_req(bk_req), .bk_wr(bk_wr), .bk_addr(bk_addr), .bk_din(bk_din),
    .bk_dout(bk_dout), .bk_ack(bk_ack), .ram(ram_bus),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM responder: ready after rdy_delay strobe cycles unless rdy_never.
  int         rdy_delay = 0;
  bit         rdy_never = 1'b0;
  logic [7:0] rdat = 8'h00;

  initial begin
    int rcnt;
    rcnt = 0;
    ram_bus.ram_ready = 1'b0;
    ram_bus.ram_dout  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if ((ram_bus.ram_rd || ram_bus.ram_we) && !rdy_never) begin
        ram_bus.ram_ready = (rcnt == rdy_delay);
        ram_bus.ram_dout  = rdat;
        rcnt++;
      end else begin
        ram_bus.ram_ready = 1'b0;
        rcnt = 0;
      end
    end
  end

  typedef struct packed {
    logic          we;
    logic [7:0]    din;
    logic [AW-1:0] addr;
  } acc_t;

  acc_t log_q[$];
  int   n_rd_rise = 0, n_we_rise = 0, n_strobe_hi = 0, n_wait_hi = 0, n_ack = 0;
  logic prev_rd = 1'b0, prev_we = 1'b0;

  always @(negedge clk) begin
    if ((ram_bus.ram_rd && !prev_rd) || (ram_bus.ram_we && !prev_we))
      log_q.push_back('{we: ram_bus.ram_we, din: ram_bus.ram_din, addr: ram_bus.ram_addr});
    if (ram_bus.ram_rd && !prev_rd) n_rd_rise++;
    if (ram_bus.ram_we && !prev_we) n_we_rise++;
    if (ram_bus.ram_rd || ram_bus.ram_we) n_strobe_hi++;
    if (cpu_wait) n_wait_hi++;
    if (bk_ack) n_ack++;
    prev_rd = ram_bus.ram_rd;
    prev_we = ram_bus.ram_we;
  end

  int s_rd, s_we, s_hi, s_wait, s_ack, s_log;

  task automatic snap();
    s_rd = n_rd_rise; s_we = n_we_rise; s_hi = n_strobe_hi;
    s_wait = n_wait_hi; s_ack = n_ack; s_log = log_q.size();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; done reports cpu_wait fell within budget.
  task automatic cpu_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] din,
                            input logic unm, input logic wen, output logic done);
    cpu_wr = wr; cpu_addr = addr; cpu_din = din; cpu_unmaped = unm; cpu_wr_en = wen;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!cpu_wait) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic bk_access(input logic wr, input logic [AW-1:0] addr, input logic [7:0] din,
                           output logic done);
    bk_wr = wr; bk_addr = addr; bk_din = din; bk_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (bk_ack) begin
        done = 1'b1;
        break;
      end
    end
    bk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic d, d2;
    acc_t e;

    cycles(3);
    check("rst_cpu_dout",  64'(cpu_dout), 64'h FF);
    check("rst_bk_dout",   64'(bk_dout), 64'h FF);
    check("rst_cpu_wait",  64'(cpu_wait), 64'h0);
    check("rst_bk_ack",    64'(bk_ack), 64'h0);
    check("rst_strobes",   64'({ram_bus.ram_rd, ram_bus.ram_we}), 64'h0);
    check("rst_ram_addr",  64'(ram_bus.ram_addr), 64'h0);
    check("rst_errs",      64'({err_timeout, err_overrun}), 64'h0);
    reset = 1'b0;
    cycles(2);

    // CPU read, ready two cycles after the strobe rises
    rdy_delay = 2; rdat = 8'h5A;
    snap();
    cpu_access(1'b0, 25'h0080123, 8'h00, 1'b0, 1'b1, d);
    check("rd_done",      64'(d), 64'h1);
    check("rd_dout",      64'(cpu_dout), 64'h5A);
    check("rd_wait_cyc",  64'(n_wait_hi - s_wait), 64'd5);
    check("rd_rd_rises",  64'(n_rd_rise - s_rd), 64'd1);
    check("rd_we_rises",  64'(n_we_rise - s_we), 64'd0);
    e = log_q[log_q.size() - 1];
    check("rd_addr",      64'(e.addr), 64'h0080123);
    cycles(2);

    // Protected write
    snap();
    cpu_access(1'b1, 25'h0000010, 8'hC3, 1'b0, 1'b0, d);
    check("prot_done",     64'(d), 64'h1);
    check("prot_we_rises", 64'(n_we_rise - s_we), 64'd0);
    check("prot_wait_cyc", 64'(n_wait_hi - s_wait), 64'd1);
    cycles(2);

    // Unmapped write
    snap();
    cpu_access(1'b1, 25'h0000020, 8'h44, 1'b1, 1'b1, d);
    check("unw_we_rises", 64'(n_we_rise - s_we), 64'd0);
    check("unw_wait_cyc", 64'(n_wait_hi - s_wait), 64'd1);
    cycles(2);

    // Unmapped read replaces the earlier 5A with FF
    snap();
    cpu_access(1'b0, 25'h0000030, 8'h00, 1'b1, 1'b0, d);
    check("unr_dout",     64'(cpu_dout), 64'hFF);
    check("unr_wait_cyc", 64'(n_wait_hi - s_wait), 64'd1);
    check("unr_strobes",  64'((n_rd_rise - s_rd) + (n_we_rise - s_we)), 64'd0);
    cycles(2);

    // Mapped write, ready on first strobe cycle: minimum latency
    rdy_delay = 0;
    snap();
    cpu_access(1'b1, 25'h1000004, 8'h3C, 1'b0, 1'b1, d);
    check("wr_done",      64'(d), 64'h1);
    check("wr_we_rises",  64'(n_we_rise - s_we), 64'd1);
    check("wr_wait_cyc",  64'(n_wait_hi - s_wait), 64'd3);
    e = log_q[log_q.size() - 1];
    check("wr_addr_din",  64'({e.din, e.addr}), 64'({8'h3C, 25'h1000004}));
    cycles(2);

    // Backup save
    rdy_delay = 1; rdat = 8'hA5;
    snap();
    bk_access(1'b0, 25'h0000F00, 8'h00, d);
    check("bk_done",      64'(d), 64'h1);
    cycles(1);
    check("bk_dout",      64'(bk_dout), 64'hA5);
    check("bk_acks",      64'(n_ack - s_ack), 64'd1);
    check("bk_rd_rises",  64'(n_rd_rise - s_rd), 64'd1);
    check("bk_no_wait",   64'(n_wait_hi - s_wait), 64'd0);
    cycles(2);

    // Starvation: CPU requests every IDLE while a restore is pending
    rdy_delay = 0; rdat = 8'h5A;
    snap();
    d = 1'b1;
    fork
      begin
        logic dd;
        for (int k = 0; k < 5; k++) begin
          cpu_access(1'b0, 25'h000ABCD, 8'h00, 1'b0, 1'b1, dd);
          if (!dd) d = 1'b0;
        end
      end
      bk_access(1'b1, 25'h1FFFFFF, 8'h77, d2);
    join
    check("stv_cpu_done", 64'(d), 64'h1);
    check("stv_bk_done",  64'(d2), 64'h1);
    check("stv_acks",     64'(n_ack - s_ack), 64'd1);
    check("stv_accesses", 64'(log_q.size() - s_log), 64'd6);
    if (log_q.size() >= s_log + 6) begin
      for (int k = 0; k < 6; k++) begin
        acc_t want;
        want = (k == 4) ? '{we: 1'b1, din: 8'h77, addr: 25'h1FFFFFF}
                        : '{we: 1'b0, din: log_q[s_log + k].din, addr: 25'h000ABCD};
        check($sformatf("stv_order%0d", k), 64'(log_q[s_log + k]), 64'(want));
      end
    end
    check("stv_dout",     64'(cpu_dout), 64'h5A);
    cycles(2);

    // Timeout with no ram_ready at all
    rdy_never = 1'b1;
    snap();
    cpu_access(1'b0, 25'h0000123, 8'h00, 1'b0, 1'b1, d);
    check("to_done",       64'(d), 64'h1);
    check("to_strobe_cyc", 64'(n_strobe_hi - s_hi), 64'd8);
    check("to_wait_cyc",   64'(n_wait_hi - s_wait), 64'd10);
    check("to_dout",       64'(cpu_dout), 64'hFF);
    check("to_err",        64'(err_timeout), 64'h1);
    rdy_never = 1'b0;
    cycles(2);

    // Overrun: second cpu_req while the first is in flight
    rdy_delay = 3; rdat = 8'h96;
    snap();
    cpu_wr = 1'b0; cpu_addr = 25'h0000456; cpu_unmaped = 1'b0; cpu_wr_en = 1'b1; cpu_req = 1'b1;
    cycles(1);
    cpu_req = 1'b0;
    cycles(1);
    cpu_addr = 25'h0000999; cpu_req = 1'b1;
    cycles(1);
    cpu_req = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!cpu_wait) begin
        d = 1'b1;
        break;
      end
      cycles(1);
    end
    check("ovr_done",     64'(d), 64'h1);
    check("ovr_err",      64'(err_overrun), 64'h1);
    check("ovr_rd_rises", 64'(n_rd_rise - s_rd), 64'd1);
    check("ovr_wait_cyc", 64'(n_wait_hi - s_wait), 64'd6);
    check("ovr_dout",     64'(cpu_dout), 64'h96);
    e = log_q[log_q.size() - 1];
    check("ovr_addr",     64'(e.addr), 64'h0000456);
    check("to_err_sticky", 64'(err_timeout), 64'h1);
    cycles(2);

    // Reset while ram_we is high
    rdy_never = 1'b1;
    cpu_wr = 1'b1; cpu_addr = 25'h0000200; cpu_din = 8'h11; cpu_unmaped = 1'b0; cpu_wr_en = 1'b1;
    cpu_req = 1'b1;
    cycles(1);
    cpu_req = 1'b0;
    d = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ram_bus.ram_we) begin
        d = 1'b1;
        break;
      end
      cycles(1);
    end
    check("rstw_we_seen", 64'(d), 64'h1);
    reset = 1'b1;
    cycles(1);
    check("rstw_we",       64'(ram_bus.ram_we), 64'h0);
    check("rstw_wait",     64'(cpu_wait), 64'h0);
    check("rstw_errs",     64'({err_timeout, err_overrun}), 64'h0);
    check("rstw_state",    64'(dut.state), 64'(IDLE));
    check("rstw_cpu_dout", 64'(cpu_dout), 64'hFF);
    reset = 1'b0;
    snap();
    cycles(6);
    check("rstw_no_resume", 64'((n_we_rise - s_we) + (n_rd_rise - s_rd)), 64'd0);
    check("rstw_wait_idle", 64'(n_wait_hi - s_wait), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
